hub75_stream_writer: RTL and testbench

HUB75_STREAM_WRITER -- requirements
Module: hub75_stream_writer

---
 rtl/hub75_stream_writer_pkg.sv | 23 ++
 rtl/hub75_stream_writer_if.sv | 13 +
 rtl/hub75_stream_writer_gamma.sv | 26 ++
 rtl/hub75_stream_writer.sv | 143 ++++++++++++++
 tb/tb_hub75_stream_writer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hub75_stream_writer_pkg.sv
// Shared types for the HUB75 stream writer: FSM states, pixel layout, width helper.
package hub75_stream_writer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    RUN
  } state_t;

  localparam int unsigned PIXEL_BITS = 8;

  typedef struct packed {
    logic [PIXEL_BITS-1:0] r;
    logic [PIXEL_BITS-1:0] g;
    logic [PIXEL_BITS-1:0] b;
  } pixel_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hub75_stream_writer_if.sv
// Video stream handshake bundle (tdata = {r,g,b}, tuser = SOF, tlast = EOL).
interface hub75_stream_writer_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [3*DATA_BITS-1:0] tdata;
  logic                   tuser;
  logic                   tlast;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/hub75_stream_writer_gamma.sv
// Registered gamma-2.2 lookup for one colour channel; only built with HUB75_STREAM_WRITER_GAMMA_EN.
`ifdef HUB75_STREAM_WRITER_GAMMA_EN
module hub75_stream_writer_gamma #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [DATA_BITS-1:0] din,
  output logic [DATA_BITS-1:0] dout
);
  localparam int unsigned ENTRIES = 1 << DATA_BITS;
  localparam real         MAXV    = real'(ENTRIES - 1);

  logic [DATA_BITS-1:0] lut [ENTRIES];

  // Table contents are elaboration-time constants: floor((i/max)^2.2 * max).
  for (genvar i = 0; i < ENTRIES; i++) begin : g_lut
    assign lut[i] = DATA_BITS'($rtoi(((real'(i) / MAXV) ** 2.2) * MAXV));
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) dout <= '0;
    else          dout <= lut[din];
  end
endmodule
`endif

// File: rtl/hub75_stream_writer.sv
// AXI-stream video to HUB75 frame-buffer writer with line/frame error detection.
// Optional gamma correction: define HUB75_STREAM_WRITER_GAMMA_EN.
module hub75_stream_writer
  import hub75_stream_writer_pkg::*;
#(
  parameter int unsigned N         = 2,
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned HEIGHT    = 32,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ADDR_BITS = $clog2(N*HEIGHT*WIDTH)
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        enable,
  hub75_stream_writer_if.slave        s,
  output logic                        mem_we,
  output logic [ADDR_BITS-1:0]        mem_addr,
  output logic [DATA_BITS-1:0]        mem_r,
  output logic [DATA_BITS-1:0]        mem_g,
  output logic [DATA_BITS-1:0]        mem_b,
  output logic                        frame_done,
  output logic                        err_line,
  output logic                        err_frame
);
  localparam int unsigned LINES = N * HEIGHT;
  localparam int unsigned XW    = idx_bits(WIDTH + 1);
  localparam int unsigned YW    = idx_bits(LINES);

  typedef struct packed {
    logic [DATA_BITS-1:0] r;
    logic [DATA_BITS-1:0] g;
    logic [DATA_BITS-1:0] b;
  } pix_t;

  state_t               state;
  logic [XW-1:0]        x;
  logic [YW-1:0]        y;
  logic                 accept;
  logic                 sof;
  logic [XW-1:0]        cx;
  logic [YW-1:0]        cy;
  logic                 we_q;
  logic [ADDR_BITS-1:0] addr_q;
  pix_t                 pix_q;

  assign s.tready = aresetn;
  assign accept   = s.tvalid & s.tready;
  assign sof      = accept & s.tuser;

  // SOF rewinds the position before the beat is placed, so SOF+EOL lands as EOL at x=0.
  always_comb begin
    cx = sof ? '0 : x;
    cy = sof ? '0 : y;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      pix_q      <= '0;
      frame_done <= 1'b0;
      err_line   <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      we_q       <= 1'b0;
      frame_done <= 1'b0;
      err_line   <= 1'b0;
      err_frame  <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        x     <= '0;
        y     <= '0;
      end else begin
        case (state)
          IDLE: state <= WAIT_SOF;
          WAIT_SOF, RUN: begin
            if (accept && (state == RUN || sof)) begin
              state     <= RUN;
              err_frame <= sof && (state == RUN);
              if (cx < XW'(WIDTH)) begin
                we_q   <= 1'b1;
                addr_q <= ADDR_BITS'(cy) * ADDR_BITS'(WIDTH) + ADDR_BITS'(cx);
                pix_q  <= s.tdata;
              end
              if (s.tlast) begin
                x <= '0;
                if (cx < XW'(WIDTH - 1)) err_line <= 1'b1;
                if (cy == YW'(LINES - 1)) begin
                  y          <= '0;
                  frame_done <= 1'b1;
                  state      <= WAIT_SOF;
                end else begin
                  y <= cy + YW'(1);
                end
              end else if (cx < XW'(WIDTH)) begin
                // x parked at WIDTH means "overlong line": drop beats until EOL.
                x <= cx + XW'(1);
                y <= cy;
                if (cx == XW'(WIDTH - 1)) err_line <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef HUB75_STREAM_WRITER_GAMMA_EN
  logic                 we_d;
  logic [ADDR_BITS-1:0] addr_d;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      we_d   <= 1'b0;
      addr_d <= '0;
    end else begin
      we_d   <= we_q;
      addr_d <= addr_q;
    end
  end

  hub75_stream_writer_gamma #(.DATA_BITS(DATA_BITS)) u_gamma_r (
    .aclk(aclk), .aresetn(aresetn), .din(pix_q.r), .dout(mem_r));
  hub75_stream_writer_gamma #(.DATA_BITS(DATA_BITS)) u_gamma_g (
    .aclk(aclk), .aresetn(aresetn), .din(pix_q.g), .dout(mem_g));
  hub75_stream_writer_gamma #(.DATA_BITS(DATA_BITS)) u_gamma_b (
    .aclk(aclk), .aresetn(aresetn), .din(pix_q.b), .dout(mem_b));

  assign mem_we   = we_d;
  assign mem_addr = addr_d;
`else
  assign mem_we   = we_q;
  assign mem_addr = addr_q;
  assign mem_r    = pix_q.r;
  assign mem_g    = pix_q.g;
  assign mem_b    = pix_q.b;
`endif

endmodule

// File: tb/tb_hub75_stream_writer.sv
// Randomised bench for hub75_stream_writer against a line-level reference model.
module tb_hub75_stream_writer;
  localparam int unsigned N      = 2;
  localparam int unsigned WIDTH  = 64;
  localparam int unsigned HEIGHT = 32;
  localparam int unsigned DB     = 8;
  localparam int unsigned AB     = 12;
  localparam int unsigned LINES  = N * HEIGHT;
`ifdef HUB75_STREAM_WRITER_GAMMA_EN
  localparam int unsigned LAT    = 2;
  localparam logic [7:0]  R80    = 8'h37;
`else
  localparam int unsigned LAT    = 1;
  localparam logic [7:0]  R80    = 8'h80;
`endif

  logic          aclk    = 1'b0;
  logic          aresetn = 1'b0;
  logic          enable  = 1'b0;
  logic          mem_we;
  logic [AB-1:0] mem_addr;
  logic [DB-1:0] mem_r, mem_g, mem_b;
  logic          frame_done, err_line, err_frame;

  hub75_stream_writer_if #(.DATA_BITS(DB)) s_if ();

  hub75_stream_writer #(
    .N(N), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .DATA_BITS(DB), .ADDR_BITS(AB)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .s(s_if),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_r(mem_r), .mem_g(mem_g), .mem_b(mem_b),
    .frame_done(frame_done), .err_line(err_line), .err_frame(err_frame)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  typedef struct { int addr; logic [23:0] pix; int cyc; } wr_t;

  int          cyc = 0;
  int          acc_cyc = 0;
  wr_t         obs_q[$];
  wr_t         exp_q[$];
  logic [23:0] obs_mem [4096];
  logic [23:0] exp_mem [4096];
  int          n_fd = 0, n_el = 0, n_ef = 0, fd_cyc = 0;
  int          e_fd = 0, e_el = 0, e_ef = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    if (aresetn) begin
      if (mem_we === 1'b1) begin
        obs_q.push_back('{int'(mem_addr), {mem_r, mem_g, mem_b}, cyc});
        obs_mem[mem_addr] = {mem_r, mem_g, mem_b};
      end
      if (frame_done === 1'b1) begin n_fd++; fd_cyc = cyc; end
      if (err_line   === 1'b1) n_el++;
      if (err_frame  === 1'b1) n_ef++;
    end
  end

  function automatic logic [7:0] chan(input logic [7:0] v);
`ifdef HUB75_STREAM_WRITER_GAMMA_EN
    return 8'($rtoi(((real'(v) / 255.0) ** 2.2) * 255.0));
`else
    return v;
`endif
  endfunction

  task automatic push_exp(input int addr, input logic [23:0] d);
    logic [23:0] p;
    p = {chan(d[23:16]), chan(d[15:8]), chan(d[7:0])};
    exp_q.push_back('{addr, p, 0});
    exp_mem[addr] = p;
  endtask

  task automatic idle_cycle();
    s_if.tvalid = 1'b0;
    s_if.tuser  = 1'($urandom_range(1));
    s_if.tlast  = 1'($urandom_range(1));
    s_if.tdata  = 24'($urandom);
    @(posedge aclk); #1;
  endtask

  task automatic beat(input logic [23:0] d, input logic sof, input logic eol);
    if ($urandom_range(7) == 0) idle_cycle();
    s_if.tdata  = d;
    s_if.tuser  = sof;
    s_if.tlast  = eol;
    s_if.tvalid = 1'b1;
    @(posedge aclk); #1;
    acc_cyc     = cyc;
    s_if.tvalid = 1'b0;
  endtask

  // Line of nbeats beats (indices start_x..nbeats-1 are sent). The model writes the
  // first WIDTH pixels; the line is in error unless exactly WIDTH beats end with EOL.
  task automatic send_line(input int y, input int nbeats, input int start_x,
                           input bit sof, input bit eol, input bit live);
    logic [23:0] d;
    for (int i = start_x; i < nbeats; i++) begin
      d = 24'($urandom);
      beat(d, sof && (i == start_x), eol && (i == nbeats - 1));
      if (live && i < int'(WIDTH)) push_exp(y * int'(WIDTH) + i, d);
    end
    if (live && ((eol && nbeats < int'(WIDTH)) || (nbeats > int'(WIDTH)) ||
                 (!eol && nbeats == int'(WIDTH))))
      e_el++;
  endtask

  task automatic send_frame(input int short_line, input int short_len);
    for (int y = 0; y < int'(LINES); y++)
      send_line(y, (y == short_line) ? short_len : int'(WIDTH), 0, y == 0, 1'b1, 1'b1);
    e_fd++;
  endtask

  task automatic verify(input string tag);
    int bad;
    repeat (4) idle_cycle();
    check_eq($sformatf("%s.nwr", tag), 64'(obs_q.size()), 64'(exp_q.size()));
    if (exp_q.size() > 0 && obs_q.size() > 0) begin
      bad = (exp_q.size() < obs_q.size() ? exp_q.size() : obs_q.size()) - 1;
      for (int i = 0; i <= bad; i++)
        if (obs_q[i].addr != exp_q[i].addr || obs_q[i].pix !== exp_q[i].pix) begin
          bad = i;
          break;
        end
      check_eq($sformatf("%s.addr[%0d]", tag, bad), 64'(obs_q[bad].addr), 64'(exp_q[bad].addr));
      check_eq($sformatf("%s.pix[%0d]", tag, bad), 64'(obs_q[bad].pix), 64'(exp_q[bad].pix));
    end
    check_eq($sformatf("%s.frame_done", tag), 64'(n_fd), 64'(e_fd));
    check_eq($sformatf("%s.err_line", tag), 64'(n_el), 64'(e_el));
    check_eq($sformatf("%s.err_frame", tag), 64'(n_ef), 64'(e_ef));
    obs_q.delete(); exp_q.delete();
    n_fd = 0; n_el = 0; n_ef = 0; e_fd = 0; e_el = 0; e_ef = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq($sformatf("%s.tready", tag), 64'(s_if.tready), 64'(0));
    check_eq($sformatf("%s.mem_we", tag), 64'(mem_we), 64'(0));
    check_eq($sformatf("%s.mem_addr", tag), 64'(mem_addr), 64'(0));
    check_eq($sformatf("%s.mem_rgb", tag), 64'({mem_r, mem_g, mem_b}), 64'(0));
    check_eq($sformatf("%s.pulses", tag), 64'({frame_done, err_line, err_frame}), 64'(0));
  endtask

  initial begin
    int first_cyc;
    s_if.tvalid = 1'b0; s_if.tuser = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0;
    repeat (3) @(posedge aclk);
    #1;
    check_reset_outputs("por");
    aresetn = 1'b1;
    #1;
    check_eq("tready_after_reset", 64'(s_if.tready), 64'(1));
    enable = 1'b1;
    repeat (3) idle_cycle();

    // Full frame; first pixel r=0x80 exercises the data path / gamma value.
    beat(24'h80_5AA5, 1'b1, 1'b0);
    push_exp(0, 24'h80_5AA5);
    first_cyc = acc_cyc;
    send_line(0, WIDTH, 1, 1'b0, 1'b1, 1'b1);
    for (int y = 1; y < int'(LINES); y++) send_line(y, WIDTH, 0, 1'b0, 1'b1, 1'b1);
    e_fd++;
    repeat (4) idle_cycle();
    check_eq("first_r", 64'(obs_q[0].pix[23:16]), 64'(R80));
    check_eq("write_latency", 64'(obs_q[0].cyc), 64'(first_cyc + int'(LAT) - 1));
    check_eq("frame_done_timing", 64'(fd_cyc), 64'(acc_cyc));
    check_eq("hold_we", 64'(mem_we), 64'(0));
    check_eq("hold_addr", 64'(mem_addr), 64'(4095));
    verify("full_frame");

    // Early EOL on line 5 at x=39.
    send_frame(5, 40);
    repeat (4) idle_cycle();
    check_eq("early_eol.next_addr", 64'(obs_q[360].addr), 64'(384));
    for (int a = 360; a < 384; a++)
      check_eq($sformatf("early_eol.keep[%0d]", a), 64'(obs_mem[a]), 64'(exp_mem[a]));
    verify("early_eol");

    // Overlong line 0: 70 beats, EOL on the 70th.
    send_frame(0, 70);
    repeat (4) idle_cycle();
    check_eq("long_line.next_addr", 64'(obs_q[64].addr), 64'(64));
    verify("long_line");

    // SOF arriving at line 10, x=3.
    for (int y = 0; y < 10; y++) send_line(y, WIDTH, 0, y == 0, 1'b1, 1'b1);
    send_line(10, 3, 0, 1'b0, 1'b0, 1'b1);
    e_ef++;
    send_frame(-1, 0);
    verify("mid_sof");

    // enable dropped during line 20; remaining beats are dropped until a fresh SOF.
    for (int y = 0; y < 20; y++) send_line(y, WIDTH, 0, y == 0, 1'b1, 1'b1);
    send_line(20, 10, 0, 1'b0, 1'b0, 1'b1);
    enable = 1'b0;
    send_line(20, 15, 10, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    repeat (2) idle_cycle();
    send_line(20, WIDTH, 15, 1'b0, 1'b1, 1'b0);
    send_line(21, WIDTH, 0, 1'b0, 1'b1, 1'b0);
    verify("enable_drop");
    send_frame(-1, 0);
    verify("after_enable");

    // Reset mid-frame, then SOF+EOL on one beat while running.
    for (int y = 0; y < 3; y++) send_line(y, WIDTH, 0, y == 0, 1'b1, 1'b1);
    send_line(3, 20, 0, 1'b0, 1'b0, 1'b1);
    idle_cycle();
    aresetn = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    repeat (2) idle_cycle();
    send_line(3, WIDTH, 20, 1'b0, 1'b1, 1'b0);
    send_line(0, WIDTH, 0, 1'b1, 1'b1, 1'b1);
    beat(24'h12_3456, 1'b1, 1'b1);
    push_exp(0, 24'h12_3456);
    e_el++; e_ef++;
    send_line(1, 1, 0, 1'b0, 1'b1, 1'b1);
    verify("reset_and_sof_eol");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
